boot_loader_dma: RTL and testbench

Parametrised boot-time loader that walks a descriptor list in the boot ROM and streams each described block from main memory into one of up to four destination memories (IM, DM, …). It sits between the boot ROM, the main-memory read port and the destination write ports, and releases the CPU by asserting `done`. Compared with the earlier loader it adds:

- a real data path;
- per-channel write pointers;
- a one-word-per-cycle pipelined copy;
- end-of-list, skip and error handling.

---
 rtl/boot_loader_pkg.sv | 41 ++++
 rtl/boot_copy_engine.sv | 58 +++++
 rtl/boot_loader_dma.sv | 155 +++++++++++++++
 tb/tb_boot_loader_dma.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types for the boot-time descriptor loader: descriptor layout, FSM states
// and the hard upper limit on destination channels.
package boot_loader_pkg;

    localparam int MAX_DST  = 4;

    localparam int DESC_W   = 36;
    localparam int SKIP_BIT = 35;
    localparam int EN_BIT   = 34;
    localparam int CH_LSB   = 32;
    localparam int CH_W     = 2;
    localparam int SRC_LSB  = 16;
    localparam int SRC_W    = 16;
    localparam int SIZE_LSB = 0;
    localparam int SIZE_W   = 16;

    typedef struct packed {
        logic              skip;
        logic              en;
        logic [CH_W-1:0]   ch;
        logic [SRC_W-1:0]  src;
        logic [SIZE_W-1:0] size;
    } desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_COPY,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } state_e;

    // An all-zero word terminates the descriptor list.
    function automatic logic desc_is_end(input desc_t d);
        return d == '0;
    endfunction

endpackage

// File: rtl/boot_copy_engine.sv
// Source/count counters and the one-stage read->write pipeline: a word read in one
// cycle is presented for writing in the next, one word per cycle, no back-pressure.
module boot_copy_engine
    import boot_loader_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int DW     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [MEM_AW-1:0] load_src_i,
    input  logic [SIZE_W-1:0] load_cnt_i,
    input  logic              issue_i,
    output logic              last_o,
    output logic              mem_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic              wr_vld_o,
    output logic [DW-1:0]     wr_data_o
);

    logic [MEM_AW-1:0] src_q, src_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic              wr_vld_q, wr_vld_d;

    always_comb begin
        src_d    = src_q;
        cnt_d    = cnt_q;
        wr_vld_d = issue_i;
        if (load_i) begin
            src_d = load_src_i;
            cnt_d = load_cnt_i;
        end else if (issue_i) begin
            src_d = src_q + MEM_AW'(1);
            cnt_d = cnt_q - SIZE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            src_q    <= '0;
            cnt_q    <= '0;
            wr_vld_q <= 1'b0;
        end else begin
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            wr_vld_q <= wr_vld_d;
        end
    end

    assign last_o     = (cnt_q == SIZE_W'(1));
    assign mem_en_o   = issue_i;
    assign mem_addr_o = issue_i ? src_q : '0;
    assign wr_vld_o   = wr_vld_q;
    assign wr_data_o  = wr_vld_q ? mem_rdata_i : '0;

endmodule

// File: rtl/boot_loader_dma.sv
// Boot loader: walks the ROM descriptor list, streams each block from main memory
// into its destination channel, then raises done (or error) and holds it.
module boot_loader_dma
    import boot_loader_pkg::*;
#(
    parameter int                ROM_AW   = 8,
    parameter int                MEM_AW   = 14,
    parameter int                DST_AW   = 10,
    parameter int                DW       = 32,
    parameter int                NUM_DST  = 2,
    parameter logic [DST_AW-1:0] DST_BASE = 'h80
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               rom_en,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [DESC_W-1:0]  rom_data,
    output logic               mem_en,
    output logic [MEM_AW-1:0]  mem_addr,
    input  logic [DW-1:0]      mem_rdata,
    output logic [NUM_DST-1:0] dst_we,
    output logic [DST_AW-1:0]  dst_addr,
    output logic [DW-1:0]      dst_wdata,
    output logic               busy,
    output logic               done,
    output logic               error
);

    if (NUM_DST < 1 || NUM_DST > MAX_DST) begin : g_bad_num_dst
        $error("boot_loader_dma: NUM_DST must be 1..%0d", MAX_DST);
    end

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    desc_t             desc_q, desc_d;
    logic [DST_AW-1:0] ptr_q [NUM_DST];
    logic [DST_AW-1:0] ptr_d [NUM_DST];

    logic ptr_init, load, issue, last, advance, wr_vld;

    // NOTE: every combinational output gets its default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        desc_d     = desc_q;
        ptr_init   = 1'b0;
        load       = 1'b0;
        issue      = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    rom_addr_d = '0;
                    ptr_init   = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                desc_d  = desc_t'(rom_data);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (desc_is_end(desc_q))                state_d = ST_DONE;
                else if (desc_q.skip)                   advance = 1'b1;
                else if (!desc_q.en)                    state_d = ST_ERR;
                else if (int'(desc_q.ch) >= NUM_DST)    state_d = ST_ERR;
                else if (desc_q.size == '0)             advance = 1'b1;
                else begin
                    load    = 1'b1;
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                issue = 1'b1;
                if (last) state_d = ST_DRAIN;
            end
            ST_DRAIN: advance = 1'b1;
            default:  state_d = ST_IDLE;
        endcase

        // Moving past the last ROM word would wrap onto descriptor 0, so it aborts instead.
        if (advance) begin
            if (rom_addr_q == '1) begin
                state_d = ST_ERR;
            end else begin
                rom_addr_d = rom_addr_q + ROM_AW'(1);
                state_d    = ST_FETCH;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            ptr_d[i] = ptr_q[i];
            if (ptr_init)
                ptr_d[i] = DST_BASE;
            else if (wr_vld && desc_q.ch == CH_W'(i))
                ptr_d[i] = ptr_q[i] + DST_AW'(1);
        end
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            desc_q     <= '0;
            for (int i = 0; i < NUM_DST; i++) ptr_q[i] <= DST_BASE;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            desc_q     <= desc_d;
            for (int i = 0; i < NUM_DST; i++) ptr_q[i] <= ptr_d[i];
        end
    end

    boot_copy_engine #(
        .MEM_AW (MEM_AW),
        .DW     (DW)
    ) u_copy (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .load_src_i  (MEM_AW'(desc_q.src)),
        .load_cnt_i  (desc_q.size),
        .issue_i     (issue),
        .last_o      (last),
        .mem_en_o    (mem_en),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .wr_vld_o    (wr_vld),
        .wr_data_o   (dst_wdata)
    );

    always_comb begin
        dst_we   = '0;
        dst_addr = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            if (wr_vld && desc_q.ch == CH_W'(i)) begin
                dst_we[i] = 1'b1;
                dst_addr  = ptr_q[i];
            end
        end
    end

    assign rom_en   = (state_q == ST_FETCH);
    assign rom_addr = rom_addr_q;
    assign busy     = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERR);

endmodule

// File: tb/tb_boot_loader_dma.sv
// Randomised bench for boot_loader_dma: ROM/memory models, a list-level reference
// model of the expected write stream and timing, and a write monitor.
module tb_boot_loader_dma;

    localparam int ROM_AW    = 8;
    localparam int MEM_AW    = 14;
    localparam int DST_AW    = 10;
    localparam int DW        = 32;
    localparam int NUM_DST   = 2;
    localparam int DST_BASE  = 'h80;
    localparam int ROM_DEPTH = 1 << ROM_AW;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int DST_DEPTH = 1 << DST_AW;
    localparam int LIMIT     = 20000;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               rom_en;
    logic [ROM_AW-1:0]  rom_addr;
    logic [35:0]        rom_data = '0;
    logic               mem_en;
    logic [MEM_AW-1:0]  mem_addr;
    logic [DW-1:0]      mem_rdata = '0;
    logic [NUM_DST-1:0] dst_we;
    logic [DST_AW-1:0]  dst_addr;
    logic [DW-1:0]      dst_wdata;
    logic               busy, done, error;

    always #5 clock = ~clock;

    boot_loader_dma #(
        .ROM_AW   (ROM_AW),
        .MEM_AW   (MEM_AW),
        .DST_AW   (DST_AW),
        .DW       (DW),
        .NUM_DST  (NUM_DST),
        .DST_BASE (DST_AW'(DST_BASE))
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dst_we    (dst_we),
        .dst_addr  (dst_addr),
        .dst_wdata (dst_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    logic [35:0]   rom [ROM_DEPTH];
    logic [DW-1:0] mem [MEM_DEPTH];

    // Synchronous memories: data appears the cycle after the enable; junk otherwise.
    always @(posedge clock) begin
        if (rom_en) rom_data <= rom[rom_addr];
        mem_rdata <= mem_en ? mem[mem_addr] : DW'($urandom);
    end

    typedef struct {
        int            ch;
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input bit skip, input bit en, input int ch,
                                       input int src, input int size);
        return {skip, en, ch[1:0], src[15:0], size[15:0]};
    endfunction

    function automatic logic [35:0] rand_desc();
        int kind = $urandom_range(0, 11);
        int src;
        case (kind)
            0:       return mk(1, 1'($urandom), $urandom_range(0, 3), $urandom, $urandom);
            1:       return mk(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(1, 8));
            2:       return mk(0, 1, $urandom_range(2, 3), $urandom, $urandom_range(1, 8));
            3:       return mk(0, 1, $urandom_range(0, 1), $urandom, 0);
            default: begin
                src = ($urandom_range(0, 3) == 0) ? 'h3FFA + $urandom_range(0, 5) : $urandom;
                return mk(0, 1, $urandom_range(0, 1), src, $urandom_range(1, 8));
            end
        endcase
    endfunction

    // Walks the ROM as the list semantics describe, producing the expected writes,
    // the number of clock edges from start to the final flag, and which flag.
    task automatic model_list(output int cyc, output bit exp_done, output bit exp_err);
        int          ptr [4];
        int          a, ch, src, size;
        bit          adv;
        logic [35:0] w;
        for (int i = 0; i < 4; i++) ptr[i] = DST_BASE;
        a = 0; cyc = 0; exp_done = 0; exp_err = 0;
        while (1) begin
            w    = rom[a];
            ch   = int'(w[33:32]);
            src  = int'(w[31:16]);
            size = int'(w[15:0]);
            adv  = 0;
            cyc += 3;
            if (w == '0) begin
                exp_done = 1;
                break;
            end else if (w[35]) adv = 1;
            else if (!w[34]) begin
                exp_err = 1;
                break;
            end else if (ch >= NUM_DST) begin
                exp_err = 1;
                break;
            end else if (size == 0) adv = 1;
            else begin
                for (int k = 0; k < size; k++) begin
                    exp_q.push_back('{ch, ptr[ch], mem[(src + k) % MEM_DEPTH]});
                    ptr[ch] = (ptr[ch] + 1) % DST_DEPTH;
                end
                cyc += size + 1;
                adv = 1;
            end
            if (adv) begin
                if (a == ROM_DEPTH - 1) begin
                    exp_err = 1;
                    break;
                end
                a++;
            end
        end
    endtask

    always @(negedge clock) begin : monitor
        int  ch;
        wr_t w;
        if (dst_we != '0) begin
            ch = -1;
            for (int i = 0; i < NUM_DST; i++) if (dst_we[i]) ch = i;
            check("we_onehot", 64'($onehot(dst_we)), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(dst_we), 0);
            end else begin
                w = exp_q.pop_front();
                check("wr_ch", 64'(ch), 64'(w.ch));
                check("wr_addr", 64'(dst_addr), 64'(w.addr));
                check("wr_data", 64'(dst_wdata), 64'(w.data));
            end
        end
    end

    task automatic rom_clear();
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rom_en"},    64'(rom_en),    0);
        check({tag, "_rom_addr"},  64'(rom_addr),  0);
        check({tag, "_mem_en"},    64'(mem_en),    0);
        check({tag, "_mem_addr"},  64'(mem_addr),  0);
        check({tag, "_dst_we"},    64'(dst_we),    0);
        check({tag, "_dst_addr"},  64'(dst_addr),  0);
        check({tag, "_dst_wdata"}, 64'(dst_wdata), 0);
        check({tag, "_busy"},      64'(busy),      0);
        check({tag, "_done"},      64'(done),      0);
        check({tag, "_error"},     64'(error),     0);
    endtask

    // Runs the current ROM list; cyc_o counts edges after the one that sampled start.
    // With poke set, start is pulsed again mid-list and must be ignored.
    task automatic run_list(input string tag, input bit poke, output int cyc_o);
        int exp_cyc, cyc;
        bit exp_done, exp_err;
        exp_q.delete();
        model_list(exp_cyc, exp_done, exp_err);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy_run"}, 64'(busy), 1);
        check({tag, "_flags_clr"}, 64'({done, error}), 0);
        cyc = 0;
        while (!(done || error) && cyc < LIMIT) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            start = poke && (cyc == 2);
        end
        start = 1'b0;
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_busy_end"}, 64'(busy), 0);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 0);
        cyc_o = cyc;
    endtask

    initial begin
        int cyc;
        int n_left;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
        rom_clear();

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("idle");

        // Single copy: 4 words from 0x10 to channel 0, 3 + 4 + 1 + 3 edges to done.
        rom[0] = mk(0, 1, 0, 'h10, 4);
        run_list("single", 0, cyc);
        check("single_latency", 64'(cyc), 11);

        // Append on channel 0, then channel 1; a start mid-list must be ignored.
        rom_clear();
        rom[0] = mk(0, 1, 0, 'h200, 2);
        rom[1] = mk(0, 1, 0, 'h300, 3);
        rom[2] = mk(0, 1, 1, 'h400, 1);
        run_list("append", 1, cyc);

        // Skip (even with an out-of-range channel) and size zero produce no writes.
        rom_clear();
        rom[0] = mk(1, 0, 3, 'h1234, 7);
        rom[1] = mk(0, 1, 1, 'h50, 0);
        run_list("skip_size0", 0, cyc);

        rom_clear();
        rom[0] = mk(0, 0, 0, 'h20, 5);
        run_list("err_en0", 0, cyc);

        rom[0] = mk(0, 1, 3, 'h20, 5);
        run_list("err_ch3", 0, cyc);

        rom_clear();
        rom[0] = mk(0, 1, 0, 'h10, 4);
        run_list("rerun", 0, cyc);

        // Source wrap at 0x3FFF and channel-1 pointer wrap from 0x3FF to 0x000.
        rom_clear();
        rom[0] = mk(0, 1, 1, 'h1000, 'h37E);
        rom[1] = mk(0, 1, 1, 'h3FFE, 3);
        run_list("wrap", 0, cyc);

        // A copy in the last ROM word cannot advance and must abort after its writes.
        rom_clear();
        for (int i = 0; i < ROM_DEPTH - 1; i++) rom[i] = mk(1, 0, 0, 0, 0);
        rom[ROM_DEPTH-1] = mk(0, 1, 1, 'h100, 2);
        run_list("rom_end", 0, cyc);

        for (int t = 0; t < 20; t++) begin
            rom_clear();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) rom[i] = rand_desc();
            run_list($sformatf("rand%0d", t), 0, cyc);
        end

        // Reset while the second of eight words is in flight.
        rom_clear();
        rom[0] = mk(0, 1, 0, $urandom, 8);
        exp_q.delete();
        model_list(cyc, n_left[0], n_left[1]);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("rst_mid");
        check("rst_mid_writes", 64'(8 - exp_q.size()), 1);
        exp_q.delete();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            check("rst_quiet_we", 64'(dst_we), 0);
            check("rst_quiet_busy", 64'(busy), 0);
        end
        run_list("rst_rerun", 0, cyc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
